// File: rtl/systolic_uart_sequencer_pkg.sv
// Shared types and constants for the UART-driven 3x3 systolic matrix sequencer.
package systolic_uart_sequencer_pkg;

    localparam int unsigned N           = 3;
    localparam int unsigned FEED_CYCLES = 2 * N + 1;
    localparam int unsigned RES_BYTES   = 3;

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StClear,
        StFeed,
        StDrain,
        StCapture,
        StSend
    } seq_state_e;

    // Width of one array product: full product plus headroom for the 3-term sum.
    function automatic int unsigned calc_pw(int unsigned dw);
        return 2 * dw + 2;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// Combinational diagonal skew: row i of A and column j of B enter the array delayed by i/j cycles.
module systolic_skew_feeder
    import systolic_uart_sequencer_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic [N*N*DATAWIDTH-1:0] a_flat,
    input  logic [N*N*DATAWIDTH-1:0] b_flat,
    input  logic [2:0]               t,
    output logic [DATAWIDTH-1:0]     a0,
    output logic [DATAWIDTH-1:0]     a1,
    output logic [DATAWIDTH-1:0]     a2,
    output logic [DATAWIDTH-1:0]     b0,
    output logic [DATAWIDTH-1:0]     b1,
    output logic [DATAWIDTH-1:0]     b2
);

    logic [DATAWIDTH-1:0] a_skew [N];
    logic [DATAWIDTH-1:0] b_skew [N];

    always_comb begin
        int d;
        d = 0;
        for (int i = 0; i < int'(N); i++) begin
            a_skew[i] = '0;
            b_skew[i] = '0;
            d = int'(t) - i;
            if (d >= 0 && d < int'(N)) begin
                // Elements are row-major with element (0,0) in the LSBs.
                a_skew[i] = a_flat[(i * int'(N) + d) * int'(DATAWIDTH) +: DATAWIDTH];
                b_skew[i] = b_flat[(d * int'(N) + i) * int'(DATAWIDTH) +: DATAWIDTH];
            end
        end
    end

    assign a0 = a_skew[0];
    assign a1 = a_skew[1];
    assign a2 = a_skew[2];
    assign b0 = b_skew[0];
    assign b1 = b_skew[1];
    assign b2 = b_skew[2];

endmodule

// File: rtl/systolic_uart_sequencer.sv
// Loads A and B from the UART, feeds the systolic array with skew, drains it and
// streams the nine products back out, three bytes each, LSB first.
module systolic_uart_sequencer
    import systolic_uart_sequencer_pkg::*;
#(
    parameter  int unsigned DATAWIDTH    = 8,
    parameter  int unsigned DRAIN_CYCLES = 4,
    localparam int unsigned PW           = calc_pw(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 arr_clear,
    output logic                 arr_en,
    output logic [DATAWIDTH-1:0] arr_a0,
    output logic [DATAWIDTH-1:0] arr_a1,
    output logic [DATAWIDTH-1:0] arr_a2,
    output logic [DATAWIDTH-1:0] arr_b0,
    output logic [DATAWIDTH-1:0] arr_b1,
    output logic [DATAWIDTH-1:0] arr_b2,
    input  logic [N*N*PW-1:0]    arr_p,
    output logic                 busy,
    output logic                 done,
    output logic                 rx_drop
);

    localparam int unsigned RW = 8 * RES_BYTES;

    seq_state_e                  state_q;
    logic [3:0]                  cnt_q;
    logic [2:0]                  t_q;
    logic [7:0]                  drain_q;
    logic [3:0]                  res_idx_q;
    logic [1:0]                  sub_q;
    logic                        gap_q;
    logic [N*N*DATAWIDTH-1:0]    a_q;
    logic [N*N*DATAWIDTH-1:0]    b_q;
    logic [N*N*PW-1:0]           res_q;

    logic [DATAWIDTH-1:0] feed_a0, feed_a1, feed_a2;
    logic [DATAWIDTH-1:0] feed_b0, feed_b1, feed_b2;
    logic [PW-1:0]        cur_res;
    logic [RW-1:0]        cur_ext;
    logic [7:0]           cur_byte;
    logic                 last_byte;
    logic                 feeding;

    systolic_skew_feeder #(
        .DATAWIDTH (DATAWIDTH)
    ) u_feeder (
        .a_flat (a_q),
        .b_flat (b_q),
        .t      (t_q),
        .a0     (feed_a0),
        .a1     (feed_a1),
        .a2     (feed_a2),
        .b0     (feed_b0),
        .b1     (feed_b1),
        .b2     (feed_b2)
    );

    // Data is only presented during FEED; DRAIN advances the array with zeros.
    assign feeding = (state_q == StFeed);
    assign arr_a0  = feeding ? feed_a0 : '0;
    assign arr_a1  = feeding ? feed_a1 : '0;
    assign arr_a2  = feeding ? feed_a2 : '0;
    assign arr_b0  = feeding ? feed_b0 : '0;
    assign arr_b1  = feeding ? feed_b1 : '0;
    assign arr_b2  = feeding ? feed_b2 : '0;

    assign busy = !(state_q == StLoadA && cnt_q == '0);

    always_comb begin
        cur_res   = res_q[int'(res_idx_q) * PW +: PW];
        cur_ext   = RW'(cur_res);
        cur_byte  = cur_ext[int'(sub_q) * 8 +: 8];
        last_byte = (res_idx_q == 4'(N * N - 1)) && (sub_q == 2'(RES_BYTES - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StLoadA;
            cnt_q     <= '0;
            t_q       <= '0;
            drain_q   <= '0;
            res_idx_q <= '0;
            sub_q     <= '0;
            gap_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            arr_clear <= 1'b0;
            arr_en    <= 1'b0;
            done      <= 1'b0;
            rx_drop   <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            arr_clear <= 1'b0;
            done      <= 1'b0;

            if (rx_valid && state_q != StLoadA && state_q != StLoadB) begin
                rx_drop <= 1'b1;
            end

            case (state_q)
                StLoadA: begin
                    if (rx_valid) begin
                        a_q[int'(cnt_q) * DATAWIDTH +: DATAWIDTH] <= rx_data;
                        if (cnt_q == 4'(N * N - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StLoadB;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StLoadB: begin
                    if (rx_valid) begin
                        b_q[int'(cnt_q) * DATAWIDTH +: DATAWIDTH] <= rx_data;
                        if (cnt_q == 4'(N * N - 1)) begin
                            cnt_q     <= '0;
                            arr_clear <= 1'b1;
                            state_q   <= StClear;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StClear: begin
                    t_q     <= '0;
                    arr_en  <= 1'b1;
                    state_q <= StFeed;
                end
                StFeed: begin
                    if (t_q == 3'(FEED_CYCLES - 1)) begin
                        drain_q <= '0;
                        state_q <= StDrain;
                    end else begin
                        t_q <= t_q + 3'd1;
                    end
                end
                StDrain: begin
                    if (drain_q == 8'(DRAIN_CYCLES - 1)) begin
                        arr_en  <= 1'b0;
                        state_q <= StCapture;
                    end else begin
                        drain_q <= drain_q + 8'd1;
                    end
                end
                StCapture: begin
                    res_q     <= arr_p;
                    res_idx_q <= '0;
                    sub_q     <= '0;
                    gap_q     <= 1'b0;
                    state_q   <= StSend;
                end
                StSend: begin
                    if (tx_start) begin
                        // done was raised together with the final strobe.
                        if (done) begin
                            res_idx_q <= '0;
                            sub_q     <= '0;
                            t_q       <= '0;
                            drain_q   <= '0;
                            state_q   <= StLoadA;
                        end else begin
                            gap_q <= 1'b1;
                            if (sub_q == 2'(RES_BYTES - 1)) begin
                                sub_q     <= '0;
                                res_idx_q <= res_idx_q + 4'd1;
                            end else begin
                                sub_q <= sub_q + 2'd1;
                            end
                        end
                    end else if (gap_q) begin
                        // Give the transmitter a cycle to raise tx_busy.
                        gap_q <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= cur_byte;
                        done     <= last_byte;
                    end
                end
                default: state_q <= StLoadA;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_uart_sequencer.sv
// Bench: 3x3 systolic array and UART transmitter models around the sequencer, results
// checked against a plain matrix product.
module tb_systolic_uart_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2 * DW + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   rx_data = '0;
    logic            rx_valid = 1'b0;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic            arr_clear, arr_en;
    logic [DW-1:0]   arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2;
    logic [9*PW-1:0] arr_p;
    logic            busy, done, rx_drop;

    int checks = 0;
    int passes = 0;
    int A [9];
    int B [9];

    always #5 clk = ~clk;

    systolic_uart_sequencer #(
        .DATAWIDTH    (DW),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .arr_clear (arr_clear),
        .arr_en    (arr_en),
        .arr_a0    (arr_a0),
        .arr_a1    (arr_a1),
        .arr_a2    (arr_a2),
        .arr_b0    (arr_b0),
        .arr_b1    (arr_b1),
        .arr_b2    (arr_b2),
        .arr_p     (arr_p),
        .busy      (busy),
        .done      (done),
        .rx_drop   (rx_drop)
    );

    // Output-stationary systolic array: a flows right, b flows down, each PE accumulates.
    logic [31:0] acc [3][3];
    logic [7:0]  ar  [3][3];
    logic [7:0]  br  [3][3];

    function automatic logic [7:0] a_in(int i, int j);
        if (j == 0) return (i == 0) ? arr_a0 : (i == 1) ? arr_a1 : arr_a2;
        return ar[i][j-1];
    endfunction

    function automatic logic [7:0] b_in(int i, int j);
        if (i == 0) return (j == 0) ? arr_b0 : (j == 1) ? arr_b1 : arr_b2;
        return br[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (arr_clear) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else if (arr_en) begin
                    acc[i][j] <= acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
                    ar[i][j]  <= a_in(i, j);
                    br[i][j]  <= b_in(i, j);
                end
            end
        end
    end

    always_comb begin
        arr_p = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                arr_p[(i*3+j)*PW +: PW] = acc[i][j][PW-1:0];
            end
        end
    end

    // Transmitter model: records each strobed byte, stays busy for busy_len cycles.
    logic [7:0] txq [$];
    int tx_count = 0;
    int done_count = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    bit hold_busy = 1'b0;

    always @(posedge clk) begin
        if (tx_start) begin
            txq.push_back(tx_data);
            tx_count++;
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (done) done_count++;
    end

    assign tx_busy = hold_busy || (busy_cnt > 0);

    // Reference: plain matrix product, P(r) with r = 3*i + j.
    function automatic logic [23:0] exp_p(int r);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) s += A[(r/3)*3 + k] * B[k*3 + (r%3)];
        return 24'(s);
    endfunction

    task automatic randomize_ab();
        for (int k = 0; k < 9; k++) begin
            A[k] = int'($urandom_range(0, 255));
            B[k] = int'($urandom_range(0, 255));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic load_job();
        for (int k = 0; k < 9; k++) send_byte(8'(A[k]));
        for (int k = 0; k < 9; k++) send_byte(8'(B[k]));
    endtask

    task automatic begin_job();
        txq.delete();
        tx_count   = 0;
        done_count = 0;
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        int cyc;
        cyc = 0;
        while (txq.size() < n && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = (txq.size() >= n);
    endtask

    task automatic check_job(input string name, input bit strict);
        bit ok;
        logic [23:0] got;
        wait_bytes(27, ok);
        checks++;
        if (!ok) $display("FAIL %s timeout: got %0d bytes, required 27", name, txq.size());
        else passes++;
        if (ok) begin
            for (int r = 0; r < 9; r++) begin
                got = {txq[3*r+2], txq[3*r+1], txq[3*r]};
                checks++;
                if (got !== exp_p(r))
                    $display("FAIL %s P%0d: got %06h, required %06h", name, r, got, exp_p(r));
                else passes++;
            end
        end
        if (strict) begin
            repeat (10) @(posedge clk);
            #1;
            checks++;
            if (tx_count !== 27 || done_count !== 1)
                $display("FAIL %s counts: strobes %0d done %0d, required 27 and 1",
                         name, tx_count, done_count);
            else passes++;
        end
        repeat (27) if (txq.size() > 0) void'(txq.pop_front());
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({tx_start, arr_clear, arr_en, done, busy, rx_drop} !== 6'b0 || tx_data !== 8'h00)
            $display("FAIL %s ctrl: got %b data %02h, required 000000 data 00", name,
                     {tx_start, arr_clear, arr_en, done, busy, rx_drop}, tx_data);
        else passes++;
        checks++;
        if ({arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2} !== 48'h0)
            $display("FAIL %s arr data: got %012h, required 0", name,
                     {arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2});
        else passes++;
    endtask

    task automatic test_reset();
        check_outputs_zero("reset");
    endtask

    task automatic test_identity();
        int lat;
        begin_job();
        busy_len = 0;
        for (int k = 0; k < 9; k++) begin
            A[k] = (k % 4 == 0) ? 1 : 0;
            B[k] = k + 1;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b, required 0", busy);
        else passes++;
        send_byte(8'(A[0]));
        checks++;
        if (busy !== 1'b1) $display("FAIL loading_busy: got %b, required 1", busy);
        else passes++;
        for (int k = 1; k < 9; k++) send_byte(8'(A[k]));
        for (int k = 0; k < 9; k++) send_byte(8'(B[k]));
        lat = 0;
        while (!tx_start && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 14) $display("FAIL latency: got %0d cycles, required 14", lat);
        else passes++;
        check_job("identity", 1'b1);
        checks++;
        if (rx_drop !== 1'b0) $display("FAIL identity_drop: got %b, required 0", rx_drop);
        else passes++;
    endtask

    task automatic test_max();
        bit ok;
        begin_job();
        busy_len = 2;
        for (int k = 0; k < 9; k++) begin
            A[k] = 255;
            B[k] = 255;
        end
        load_job();
        wait_bytes(3, ok);
        checks++;
        if (!ok || txq[0] !== 8'h03 || txq[1] !== 8'hFA || txq[2] !== 8'h02)
            $display("FAIL max_bytes: got %02h %02h %02h, required 03 fa 02",
                     txq[0], txq[1], txq[2]);
        else passes++;
        check_job("max", 1'b1);
    endtask

    task automatic test_feed_probe();
        begin_job();
        busy_len = 1;
        for (int k = 0; k < 9; k++) begin
            A[k] = k + 1;
            B[k] = k + 11;
        end
        load_job();
        checks++;
        if (arr_clear !== 1'b1 || arr_en !== 1'b0)
            $display("FAIL clear_cycle: got clear %b en %b, required 1 0", arr_clear, arr_en);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2} !== {8'd3, 8'd5, 8'd7, 8'd17, 8'd15, 8'd13})
            $display("FAIL feed_t2: got %0d %0d %0d / %0d %0d %0d, required 3 5 7 / 17 15 13",
                     arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2} !== {8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd19})
            $display("FAIL feed_t4: got %0d %0d %0d / %0d %0d %0d, required 0 0 9 / 0 0 19",
                     arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (arr_en !== 1'b1 || {arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2} !== 48'h0)
            $display("FAIL feed_t6: got en %b data %012h, required en 1 data 0",
                     arr_en, {arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2});
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (arr_en !== 1'b1 || {arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2} !== 48'h0)
            $display("FAIL drain_zero: got en %b data %012h, required en 1 data 0",
                     arr_en, {arr_a0, arr_a1, arr_a2, arr_b0, arr_b1, arr_b2});
        else passes++;
        check_job("feed_probe", 1'b1);
    endtask

    task automatic test_drop_in_drain();
        begin_job();
        busy_len = int'($urandom_range(0, 3));
        randomize_ab();
        load_job();
        repeat (9) @(posedge clk);
        #1;
        send_byte(8'hA5);
        checks++;
        if (rx_drop !== 1'b1) $display("FAIL drop_set: got %b, required 1", rx_drop);
        else passes++;
        check_job("drop_first", 1'b1);
        begin_job();
        randomize_ab();
        load_job();
        check_job("drop_second", 1'b1);
        checks++;
        if (rx_drop !== 1'b1) $display("FAIL drop_sticky: got %b, required 1", rx_drop);
        else passes++;
    endtask

    task automatic test_busy_stall();
        int cyc;
        begin_job();
        busy_len = int'($urandom_range(0, 3));
        randomize_ab();
        load_job();
        cyc = 0;
        while (tx_count < 5 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        hold_busy = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (tx_count !== 5 || busy !== 1'b1)
            $display("FAIL stall: got %0d strobes busy %b, required 5 and 1", tx_count, busy);
        else passes++;
        hold_busy = 1'b0;
        check_job("stall", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp1 [9];
        logic [23:0] got;
        int cyc;
        begin_job();
        busy_len = int'($urandom_range(0, 2));
        randomize_ab();
        for (int r = 0; r < 9; r++) exp1[r] = exp_p(r);
        load_job();
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (done !== 1'b1) $display("FAIL b2b_done: got %b, required 1", done);
        else passes++;
        // Byte in the done cycle must be dropped; the next job starts right after.
        send_byte(8'h5A);
        randomize_ab();
        load_job();
        checks++;
        if (txq.size() !== 27) $display("FAIL b2b_first_len: got %0d, required 27", txq.size());
        else passes++;
        if (txq.size() >= 27) begin
            for (int r = 0; r < 9; r++) begin
                got = {txq[3*r+2], txq[3*r+1], txq[3*r]};
                checks++;
                if (got !== exp1[r])
                    $display("FAIL b2b_first P%0d: got %06h, required %06h", r, got, exp1[r]);
                else passes++;
            end
        end
        begin_job();
        check_job("b2b_second", 1'b1);
    endtask

    task automatic test_reset_mid_send();
        int cyc;
        begin_job();
        busy_len = 1;
        randomize_ab();
        load_job();
        cyc = 0;
        while (tx_count < 10 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        begin_job();
        randomize_ab();
        load_job();
        check_job("after_reset", 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_identity();
        test_max();
        test_feed_probe();
        test_drop_in_drain();
        test_busy_stall();
        test_back_to_back();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
